apb_master_bridge: RTL

Synthesizable, parametrised APB master for the APB bus design. It accepts single read or write commands on a valid/ready request port and runs the APB SETUP/ACCESS sequence on the bus. It decodes one of NUM_SLV slave selects, honours PREADY wait states and PSLVERR, and aborts hung transfers after a bounded timeout. It sits between any command source (CPU model, bench sequencer or future DMA) and the APB slave register blocks.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master_bridge_if.sv | 44 ++++
 rtl/apb_slave_mux.sv | 24 ++
 rtl/apb_master_bridge.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding and slave-select width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Index width needed to address num_slv slaves; never narrower than one bit.
    function automatic int sel_width(input int num_slv);
        return (num_slv < 2) ? 1 : $clog2(num_slv);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB bus of the master bridge, bundled for connection.
interface apb_master_bridge_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_W-1:0]         cmd_addr;
    logic [DATA_W-1:0]         cmd_wdata;

    logic                      rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR;

    // Bridge side.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    // Command source and slave side.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_slave_mux.sv
// Picks ready, error and read data of the currently addressed slave from the per-slave buses.
module apb_slave_mux
    import apb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_W   = sel_width(NUM_SLV)
) (
    input  logic [SEL_W-1:0]          slv_idx,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic                      sel_ready,
    output logic                      sel_err,
    output logic [DATA_W-1:0]         sel_rdata
);

    always_comb begin
        sel_ready = pready[slv_idx];
        sel_err   = pslverr[slv_idx];
        sel_rdata = prdata[slv_idx*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB master: turns single valid/ready commands into SETUP/ACCESS transfers with
// wait-state handling, slave error reporting and a bounded ACCESS timeout.
//
// state  | meaning
// IDLE   | bus quiet, cmd_ready high, next command latched here
// SETUP  | PSEL driven, PENABLE low, one cycle
// ACCESS | PENABLE high, waiting for PREADY of the selected slave or timeout
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic SYSCLK,
    input  logic RST_B,
    apb_master_bridge_if.master bus
);

    localparam int SEL_W = sel_width(NUM_SLV);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NUM_SLV-1:0] SEL_ONE = NUM_SLV'(1);

    apb_state_t          state_q, state_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [SEL_W-1:0]    slv_idx_q, slv_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic [SEL_W-1:0]    cmd_sel;
    logic [CNT_W-1:0]    cnt_inc;

    assign cmd_sel = bus.cmd_addr[ADDR_W-1 -: SEL_W];
    assign cnt_inc = cnt_q + CNT_ONE;

    apb_slave_mux #(
        .DATA_W  (DATA_W),
        .NUM_SLV (NUM_SLV),
        .SEL_W   (SEL_W)
    ) u_slave_mux (
        .slv_idx   (slv_idx_q),
        .prdata    (bus.PRDATA),
        .pready    (bus.PREADY),
        .pslverr   (bus.PSLVERR),
        .sel_ready (sel_ready),
        .sel_err   (sel_err),
        .sel_rdata (sel_rdata)
    );

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            slv_idx_q   <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            slv_idx_q   <= slv_idx_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        slv_idx_d   = slv_idx_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    psel_d    = SEL_ONE << cmd_sel;
                    penable_d = 1'b0;
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    pwdata_d  = bus.cmd_wdata;
                    slv_idx_d = cmd_sel;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so a completion on the last allowed cycle wins over the timeout.
                if (sel_ready || (cnt_inc == CNT_TC)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_ready ? sel_err : 1'b1;
                    rsp_rdata_d = (sel_ready && !pwrite_q && !sel_err) ? sel_rdata : '0;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    state_d     = IDLE;
                end
                cnt_d = cnt_inc;
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                paddr_d   = '0;
                pwdata_d  = '0;
                state_d   = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule
